// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and validity helper for the BCD counter family.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic bit is_valid_bcd(input bcd_t v);
    return v <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter: load, step on ci, ripple terminal count out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic r,
  input  logic ci,
  input  logic up,
  input  logic ld,
  input  bcd_t d,
  output bcd_t q,
  output logic tco
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (ci) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign tco = ci & (up ? (q_q == BCD_MAX) : (q_q == BCD_MIN));

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with validated parallel load, wrap or saturate limits,
// combinational terminal count and registered carry/borrow and load-error pulses.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic                  en,
  input  logic                  up,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  co,
  output logic                  err
);

  logic [4*DIGITS-1:0] q_w;
  logic [DIGITS-1:0]   ci, tco;
  logic                ld_ok, all_max, all_min, limit, step_en;
  logic                co_q, co_d, err_q, err_d;

  always_comb begin
    ld_ok   = 1'b1;
    all_max = 1'b1;
    all_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ld_ok   = ld_ok & is_valid_bcd(d[4*i +: 4]);
      all_max = all_max & (q_w[4*i +: 4] == BCD_MAX);
      all_min = all_min & (q_w[4*i +: 4] == BCD_MIN);
    end
    limit = up ? all_max : all_min;
    tc    = en & ~ld & limit;
    // Saturation simply withholds the step, so the digit chain never wraps.
    step_en = en & ~ld & ~(SATURATE & limit);
    // The top digit's ripple-out only fires on a genuine wrap of the whole range.
    co_d  = tco[DIGITS-1];
    err_d = ld & ~ld_ok;
  end

  assign ci[0] = step_en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g > 0) begin : g_chain
      assign ci[g] = tco[g-1];
    end
    bcd_digit u_digit (
      .clk (clk),
      .r   (r),
      .ci  (ci[g]),
      .up  (up),
      .ld  (ld & ld_ok),
      .d   (d[4*g +: 4]),
      .q   (q_w[4*g +: 4]),
      .tco (tco[g])
    );
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      co_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      co_q  <= co_d;
      err_q <= err_d;
    end
  end

  assign q   = q_w;
  assign co  = co_q;
  assign err = err_q;

endmodule
